// File: rtl/kv_cache_pkg.sv
// Shared types and default dimensions for the KV cache controller slice.
package kv_cache_pkg;

   localparam int unsigned DEF_MAX_SEQ_LEN = 8;
   localparam int unsigned DEF_HEAD_DIM    = 4;
   localparam int unsigned DEF_DW          = 4;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain
   } scan_state_e;

   function automatic int unsigned kv_vec_w(input int unsigned head_dim, input int unsigned dw);
      return head_dim * dw;
   endfunction

   localparam int unsigned DEF_VEC_W = kv_vec_w(DEF_HEAD_DIM, DEF_DW);

   typedef logic [DEF_VEC_W-1:0] kv_vec_t;

endpackage

// File: rtl/kv_cache_ctrl_skid_buf.sv
// kv_skid_buf: 2-entry valid/ready buffer that falls through when empty, so a
// landing read beat reaches the output in the same cycle.
module kv_skid_buf #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   input  logic [W-1:0] in_bits,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_bits,
   output logic [1:0]   count
);

   logic [W-1:0] mem_q [2];
   logic         rd_q;
   logic         wr_q;
   logic [1:0]   cnt_q;
   logic         push;
   logic         pop;

   // The producer never lands a beat while both entries are occupied.
   assign pop       = (cnt_q != 2'd0) && out_ready;
   assign push      = in_valid && !((cnt_q == 2'd0) && out_ready);
   assign out_valid = (cnt_q != 2'd0) || in_valid;
   assign out_bits  = (cnt_q != 2'd0) ? mem_q[rd_q] : in_bits;
   assign count     = cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         cnt_q    <= 2'd0;
      end else if (flush) begin
         rd_q  <= 1'b0;
         wr_q  <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wr_q] <= in_bits;
            wr_q        <= ~wr_q;
         end
         if (pop) begin
            rd_q <= ~rd_q;
         end
         cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: rtl/kv_cache_ctrl.sv
// KV cache controller: appends head vectors to consecutive slots and streams a
// snapshot of the cache in token order. Build option: KV_SLIDING_WINDOW_EN.
module kv_cache_ctrl
   import kv_cache_pkg::*;
#(
   parameter  int unsigned MAX_SEQ_LEN = DEF_MAX_SEQ_LEN,
   parameter  int unsigned HEAD_DIM    = DEF_HEAD_DIM,
   parameter  int unsigned DW          = DEF_DW,
   localparam int unsigned AW          = $clog2(MAX_SEQ_LEN),
   localparam int unsigned VW          = kv_vec_w(HEAD_DIM, DW)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          app_valid,
   output logic          app_ready,
   input  logic [VW-1:0] app_data,
   input  logic          scan_start,
   output logic          scan_busy,
   output logic          scan_done,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [VW-1:0] out_data,
   output logic [AW-1:0] out_idx,
   output logic          out_last,
   output logic [AW:0]   seq_len,
   output logic          full,
   output logic          cache_write_en,
   output logic [AW-1:0] cache_write_addr,
   output logic [VW-1:0] cache_data_in,
   output logic [AW-1:0] cache_read_addr,
   input  logic [VW-1:0] cache_data_out
);

   localparam int unsigned BW      = VW + AW + 1;
   localparam logic [AW:0] MAX_LEN = (AW+1)'(MAX_SEQ_LEN);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0]   len_q, len_d;
   logic          app_fire;

   scan_state_e   state_q, state_d;
   logic [AW:0]   snap_q, snap_d;
   logic [AW:0]   k_q, k_d;
   logic [AW-1:0] base_q, base_d;
   logic          infl_q, infl_d;
   logic [AW-1:0] infl_idx_q, infl_idx_d;
   logic          infl_last_q, infl_last_d;
   logic [AW-1:0] rd_addr;
   logic [1:0]    sb_count;

   assign full    = (len_q == MAX_LEN);
   assign seq_len = len_q;

`ifdef KV_SLIDING_WINDOW_EN
   assign app_ready = !clear;
`else
   assign app_ready = !full && !clear;
`endif

   assign app_fire         = app_valid && app_ready;
   assign cache_write_en   = app_fire;
   assign cache_write_addr = wr_ptr_q;
   assign cache_data_in    = app_data;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      len_d    = len_q;
      if (clear) begin
         wr_ptr_d = '0;
         len_d    = '0;
      end else if (app_fire) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
         if (!full) begin
            len_d = len_q + (AW+1)'(1);
         end
      end
   end

   assign rd_addr         = base_q + k_q[AW-1:0];
   assign cache_read_addr = rd_addr;
   assign scan_busy       = (state_q != StIdle);

   always_comb begin
      state_d     = state_q;
      snap_d      = snap_q;
      k_d         = k_q;
      base_d      = base_q;
      infl_d      = 1'b0;
      infl_idx_d  = infl_idx_q;
      infl_last_d = infl_last_q;
      scan_done   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (scan_start) begin
               snap_d  = len_q;
               k_d     = '0;
`ifdef KV_SLIDING_WINDOW_EN
               // Oldest token: equals wr_ptr once full, slot 0 before wrapping.
               base_d  = wr_ptr_q - len_q[AW-1:0];
`else
               base_d  = '0;
`endif
               state_d = StRun;
            end
         end
         StRun: begin
            if (snap_q == '0) begin
               scan_done = 1'b1;
               state_d   = StIdle;
            end else if (({1'b0, infl_q} + sb_count) < 2'd2) begin
               infl_d      = 1'b1;
               infl_idx_d  = rd_addr;
               infl_last_d = (k_q == snap_q - (AW+1)'(1));
               k_d         = k_q + (AW+1)'(1);
               if (k_q == snap_q - (AW+1)'(1)) begin
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            if (!infl_q && (sb_count == 2'd0)) begin
               scan_done = 1'b1;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      if (clear) begin
         state_d   = StIdle;
         infl_d    = 1'b0;
         scan_done = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         len_q       <= '0;
         state_q     <= StIdle;
         snap_q      <= '0;
         k_q         <= '0;
         base_q      <= '0;
         infl_q      <= 1'b0;
         infl_idx_q  <= '0;
         infl_last_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         len_q       <= len_d;
         state_q     <= state_d;
         snap_q      <= snap_d;
         k_q         <= k_d;
         base_q      <= base_d;
         infl_q      <= infl_d;
         infl_idx_q  <= infl_idx_d;
         infl_last_q <= infl_last_d;
      end
   end

   logic [BW-1:0] sb_in_bits;
   logic [BW-1:0] sb_out_bits;

   assign sb_in_bits                    = {cache_data_out, infl_idx_q, infl_last_q};
   assign {out_data, out_idx, out_last} = sb_out_bits;

   kv_skid_buf #(
      .W (BW)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (clear),
      .in_valid  (infl_q),
      .in_bits   (sb_in_bits),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bits  (sb_out_bits),
      .count     (sb_count)
   );

endmodule

// File: tb/tb_kv_cache_ctrl.sv
// Randomized self-checking bench for kv_cache_ctrl against a token-queue model.
`timescale 1ns/1ps
module tb_kv_cache_ctrl;

   localparam int MAX = 8;
   localparam int AW  = 3;
   localparam int VW  = 16;
`ifdef KV_SLIDING_WINDOW_EN
   localparam bit SLIDE = 1'b1;
`else
   localparam bit SLIDE = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, clear, app_valid, app_ready, scan_start, scan_busy, scan_done;
   logic          out_valid, out_ready, out_last, full, cache_write_en;
   logic [VW-1:0] app_data, out_data, cache_data_in, cache_data_out;
   logic [AW-1:0] out_idx, cache_write_addr, cache_read_addr;
   logic [AW:0]   seq_len;

   always #5 clk = ~clk;

   kv_cache_ctrl #(
      .MAX_SEQ_LEN (MAX),
      .HEAD_DIM    (4),
      .DW          (4)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .clear            (clear),
      .app_valid        (app_valid),
      .app_ready        (app_ready),
      .app_data         (app_data),
      .scan_start       (scan_start),
      .scan_busy        (scan_busy),
      .scan_done        (scan_done),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_data         (out_data),
      .out_idx          (out_idx),
      .out_last         (out_last),
      .seq_len          (seq_len),
      .full             (full),
      .cache_write_en   (cache_write_en),
      .cache_write_addr (cache_write_addr),
      .cache_data_in    (cache_data_in),
      .cache_read_addr  (cache_read_addr),
      .cache_data_out   (cache_data_out)
   );

   // Dual-port cache with write-to-read bypass and 1-cycle read latency.
   logic [VW-1:0] mem [MAX];
   always @(posedge clk) begin
      cache_data_out <= (cache_write_en && cache_write_addr == cache_read_addr) ?
                        cache_data_in : mem[cache_read_addr];
      if (cache_write_en) mem[cache_write_addr] <= cache_data_in;
   end

   typedef struct packed {
      logic [AW-1:0] slot;
      logic [VW-1:0] data;
   } tok_t;

   tok_t toks[$];
   tok_t expq[$];
   tok_t mon_e;
   int   wr_ptr_m, start_cyc, first_beat_cyc, last_beat_cyc, nbeats, first_idx, cyc_n;
   bit   busy_m, exp_nonempty, got_first, rdy_all, prev_clear, hold_v, mon_rdy, mon_busy;
   logic [VW+AW:0] hold_bits;
   int   n_checks, n_fail;
   int   rdy_mode, pat_i;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      cyc_n++;
      if (rst) begin
         prev_clear = 1'b0;
         hold_v     = 1'b0;
      end else begin
         mon_rdy = !clear && (SLIDE || toks.size() < MAX);
         check_val("seq_len", seq_len, toks.size());
         check_val("full", full, toks.size() == MAX);
         check_val("scan_busy", scan_busy, busy_m);
         check_val("app_ready", app_ready, mon_rdy);
         check_val("wr_en", cache_write_en, app_valid && mon_rdy);
         if (app_valid && mon_rdy) begin
            check_val("wr_addr", cache_write_addr, wr_ptr_m);
            check_val("wr_data", cache_data_in, app_data);
         end
         if (prev_clear) check_val("valid_after_clear", out_valid, 0);
         if (!busy_m) check_val("valid_idle", out_valid, 0);
         if (hold_v) begin
            check_val("stall_valid", out_valid, 1);
            check_val("stall_bits", {out_data, out_idx, out_last}, hold_bits);
         end
         hold_v    = out_valid && !out_ready;
         hold_bits = {out_data, out_idx, out_last};
         if (busy_m && !out_ready) rdy_all = 1'b0;
         if (out_valid && busy_m && !got_first) begin
            got_first = 1'b1;
            first_idx = out_idx;
            if (rdy_all) check_val("first_latency", cyc_n - start_cyc, 2);
         end
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               check_val("extra_beat", 1, 0);
            end else begin
               mon_e = expq.pop_front();
               check_val("out_idx", out_idx, mon_e.slot);
               check_val("out_data", out_data, mon_e.data);
               check_val("out_last", out_last, expq.size() == 0);
               if (nbeats == 0) first_beat_cyc = cyc_n;
               nbeats++;
               last_beat_cyc = cyc_n;
            end
         end
         mon_busy = busy_m;
         if (scan_done) begin
            check_val("done_expected", busy_m && expq.size() == 0 && !clear, 1);
            if (busy_m && exp_nonempty) check_val("done_timing", cyc_n - last_beat_cyc, 1);
            if (busy_m && !exp_nonempty) check_val("done_timing0", cyc_n - start_cyc, 1);
            busy_m = 1'b0;
         end
         if (clear) begin
            toks.delete();
            expq.delete();
            wr_ptr_m = 0;
            busy_m   = 1'b0;
         end else begin
            if (scan_start && !mon_busy) begin
               expq         = toks;
               busy_m       = 1'b1;
               exp_nonempty = toks.size() > 0;
               start_cyc    = cyc_n;
               got_first    = 1'b0;
               rdy_all      = 1'b1;
               nbeats       = 0;
            end
            if (app_valid && mon_rdy) begin
               if (toks.size() == MAX) void'(toks.pop_front());
               toks.push_back({AW'(wr_ptr_m), app_data});
               wr_ptr_m = (wr_ptr_m + 1) % MAX;
            end
         end
         prev_clear = clear;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      pat_i++;
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = (pat_i % 3 == 0);
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic wait_idle(input int limit);
      int i;
      for (i = 0; i < limit && busy_m; i++) cyc();
      check_val("scan_timeout", i < limit, 1);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      cyc();
      clear = 1'b0;
   endtask

   task automatic do_scan(input int limit);
      scan_start = 1'b1;
      cyc();
      scan_start = 1'b0;
      wait_idle(limit);
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; app_valid = 1'b0; app_data = '0; scan_start = 1'b0;
      out_ready = 1'b1; rdy_mode = 0; pat_i = 0; wr_ptr_m = 0; busy_m = 1'b0;
      n_checks = 0; n_fail = 0; cyc_n = 0; nbeats = 0; first_idx = 0;
      cyc();
      cyc();
      rst = 1'b0;
      @(negedge clk);
      check_val("rst_seq_len", seq_len, 0);
      check_val("rst_full", full, 0);
      check_val("rst_busy", scan_busy, 0);
      check_val("rst_done", scan_done, 0);
      check_val("rst_valid", out_valid, 0);
      check_val("rst_last", out_last, 0);
      check_val("rst_idx", out_idx, 0);
      check_val("rst_wr_en", cache_write_en, 0);
      check_val("rst_app_ready", app_ready, 1);

      // Three appends, then a full-rate scan.
      for (int i = 1; i <= 3; i++) begin
         app_valid = 1'b1;
         app_data  = 16'(32'h1111 * i);
         cyc();
      end
      app_valid = 1'b0;
      do_scan(50);
      check_val("t1_beats", nbeats, 3);
      check_val("t1_span", last_beat_cyc - first_beat_cyc, 2);
      check_val("t1_len", seq_len, 3);

      // Fill to capacity with one extra beat offered.
      do_clear();
      for (int i = 0; i < 9; i++) begin
         app_valid = 1'b1;
         app_data  = 16'($urandom);
         cyc();
      end
      app_valid = 1'b0;
      check_val("t2_len", seq_len, 8);
      check_val("t2_full", full, 1);
      check_val("t2_ready", app_ready, SLIDE ? 1 : 0);

      // Full scan under a 1,0,0 ready pattern.
      rdy_mode = 1;
      do_scan(100);
      check_val("t3_beats", nbeats, 8);
      rdy_mode = 0;
      cyc();

      // Scan of four tokens while appending every cycle.
      do_clear();
      for (int i = 0; i < 4; i++) begin
         app_valid = 1'b1;
         app_data  = 16'($urandom);
         cyc();
      end
      scan_start = 1'b1;
      for (int i = 0; i < 12; i++) begin
         app_data = 16'($urandom);
         cyc();
         scan_start = 1'b0;
      end
      app_valid = 1'b0;
      wait_idle(50);
      check_val("t4_beats", nbeats, 4);
      check_val("t4_len", seq_len, 8);

      // Clear in the middle of a scan, then an empty scan.
      scan_start = 1'b1;
      cyc();
      scan_start = 1'b0;
      for (int i = 0; i < 20 && nbeats < 2; i++) cyc();
      do_clear();
      cyc();
      check_val("t5_len", seq_len, 0);
      check_val("t5_busy", scan_busy, 0);
      do_scan(20);
      check_val("t5_zero_beats", nbeats, 0);

`ifdef KV_SLIDING_WINDOW_EN
      do_clear();
      for (int i = 1; i <= 10; i++) begin
         app_valid = 1'b1;
         app_data  = 16'(i);
         cyc();
      end
      app_valid = 1'b0;
      do_scan(50);
      check_val("t6_first_idx", first_idx, 2);
      check_val("t6_beats", nbeats, 8);
      check_val("t6_len", seq_len, 8);
`endif

      // Random traffic.
      rdy_mode = 2;
      for (int i = 0; i < 400; i++) begin
         clear      = ($urandom_range(0, 63) == 0);
         scan_start = ($urandom_range(0, 15) == 0);
         app_valid  = ($urandom_range(0, 2) != 0) && !(SLIDE && busy_m && toks.size() == MAX);
         app_data   = 16'($urandom);
         cyc();
      end
      clear      = 1'b0;
      scan_start = 1'b0;
      app_valid  = 1'b0;
      wait_idle(100);
      check_val("final_expq", expq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
